// File: rtl/game_pkg.sv
// Shared game definitions: mode encodings and the solved-board pattern.
package game_pkg;

  typedef enum logic [1:0] {
    CHOSE_BOARD  = 2'b00,
    GAMING       = 2'b01,
    GAME_INITIAL = 2'b10,
    WINNED       = 2'b11
  } game_status_t;

  localparam int MAX_BITS = 256;

  // Solved board: cell i holds value i; bits above cells*cw are zero.
  function automatic logic [MAX_BITS-1:0] target_board(input int cells, input int cw);
    logic [MAX_BITS-1:0] b;
    b = '0;
    for (int i = 0; i < cells; i++) begin
      for (int k = 0; k < cw; k++) begin
        b[8'(i * cw + k)] = ((i >> k) & 1) != 0;
      end
    end
    return b;
  endfunction

endpackage

// File: rtl/move_stack.sv
// Circular LIFO of move indices; a push onto a full stack overwrites the oldest entry.
module move_stack #(
  parameter int DEPTH = 8,
  parameter int IW    = 2,
  parameter int HW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          push,
  input  logic          pop,
  input  logic [IW-1:0] din,
  output logic [IW-1:0] top,
  output logic [HW-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [HW-1:0] FULL = HW'(DEPTH);

  logic [IW-1:0] mem [DEPTH];
  logic [PW-1:0] wp_reg;
  logic [PW-1:0] rd_ptr;
  logic [HW-1:0] cnt_reg;

  // Newest entry sits just below the write pointer, wrapping at slot 0.
  assign rd_ptr = (wp_reg == '0) ? LAST : wp_reg - 1'b1;
  assign top    = mem[rd_ptr];
  assign count  = cnt_reg;

  always_ff @(posedge clk) begin
    if (push && !clear) begin
      mem[wp_reg] <= din;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp_reg  <= '0;
      cnt_reg <= '0;
    end else if (clear) begin
      wp_reg  <= '0;
      cnt_reg <= '0;
    end else if (push) begin
      wp_reg <= (wp_reg == LAST) ? '0 : wp_reg + 1'b1;
      if (cnt_reg != FULL) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end else if (pop && cnt_reg != '0) begin
      wp_reg  <= rd_ptr;
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

endmodule

// File: rtl/puzzle_core.sv
// Cyclic-swap puzzle: edge-detected buttons swap neighbouring cells, with undo history.
module puzzle_core
  import game_pkg::*;
#(
  parameter int CELLS  = 4,
  parameter int CW     = 3,
  parameter int DEPTH  = 8,
  parameter int MOVE_W = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [1:0]                   game_status,
  input  logic [CELLS-1:0]             act,
  input  logic                         undo,
  input  logic [CELLS*CW-1:0]          origin_bd,
  output logic [CELLS*CW-1:0]          out_pc,
  output logic                         win_flag,
  output logic [MOVE_W-1:0]            move_cnt,
  output logic [$clog2(DEPTH+1)-1:0]   hist_cnt,
  output logic                         illegal
);

  localparam int IW = $clog2(CELLS);
  localparam int HW = $clog2(DEPTH + 1);
  localparam int BW = CELLS * CW;
  localparam logic [MAX_BITS-1:0] TARGET_ALL = target_board(CELLS, CW);
  localparam logic [BW-1:0]       TARGET     = TARGET_ALL[BW-1:0];
  localparam logic [MOVE_W-1:0]   MOVE_MAX   = '1;

  game_status_t      status;
  logic [CELLS-1:0]  act_q_reg;
  logic              undo_q_reg;
  logic              armed_reg;
  logic [BW-1:0]     pc_reg;
  logic              win_reg;
  logic [MOVE_W-1:0] move_reg;
  logic              ill_reg;

  logic [CELLS-1:0]  act_press;
  logic              undo_press;
  logic              multi, single_act, single_undo;
  logic              live, do_push, do_pop, reject, stack_clear;
  logic [IW-1:0]     act_idx, pop_idx, swap_idx;
  logic [BW-1:0]     swapped;
  logic [HW-1:0]     stack_cnt;

  assign status     = game_status_t'(game_status);
  assign act_press  = act & ~act_q_reg;
  assign undo_press = undo & ~undo_q_reg;

  always_comb begin
    act_idx = '0;
    for (int i = 0; i < CELLS; i++) begin
      if (act_press[i]) act_idx = IW'(i);
    end
  end

  // armed_reg masks the first edge after reset so held buttons are not presses.
  assign multi       = ($countones(act_press) + int'(undo_press)) > 1;
  assign single_act  = ($countones(act_press) == 1) && !undo_press;
  assign single_undo = undo_press && (act_press == '0);
  assign live        = armed_reg && (status == GAMING);
  assign do_push     = live && single_act;
  assign do_pop      = live && single_undo && (stack_cnt != '0);
  assign reject      = live && (multi || (single_undo && stack_cnt == '0));
  assign stack_clear = (status == CHOSE_BOARD) || (status == GAME_INITIAL);
  assign swap_idx    = single_undo ? pop_idx : act_idx;

  generate
    for (genvar gi = 0; gi < CELLS; gi++) begin : g_swap
      localparam int NXT = (gi + 1) % CELLS;
      localparam int PRV = (gi + CELLS - 1) % CELLS;
      assign swapped[gi*CW +: CW] =
        (swap_idx == IW'(gi))  ? pc_reg[NXT*CW +: CW] :
        (swap_idx == IW'(PRV)) ? pc_reg[PRV*CW +: CW] :
                                 pc_reg[gi*CW +: CW];
    end
  endgenerate

  move_stack #(.DEPTH(DEPTH), .IW(IW), .HW(HW)) u_stack (
    .clk   (clk),
    .reset (reset),
    .clear (stack_clear),
    .push  (do_push),
    .pop   (do_pop),
    .din   (act_idx),
    .top   (pop_idx),
    .count (stack_cnt)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      act_q_reg  <= '0;
      undo_q_reg <= 1'b0;
      armed_reg  <= 1'b0;
      pc_reg     <= '0;
      win_reg    <= 1'b0;
      move_reg   <= '0;
      ill_reg    <= 1'b0;
    end else begin
      act_q_reg  <= act;
      undo_q_reg <= undo;
      armed_reg  <= 1'b1;
      ill_reg    <= reject;
      case (status)
        CHOSE_BOARD, GAME_INITIAL: begin
          pc_reg   <= origin_bd;
          move_reg <= '0;
          win_reg  <= 1'b0;
        end
        GAMING: begin
          win_reg <= (pc_reg == TARGET);
          if (do_push) begin
            pc_reg <= swapped;
            if (move_reg != MOVE_MAX) move_reg <= move_reg + 1'b1;
          end else if (do_pop) begin
            pc_reg <= swapped;
            if (move_reg != '0) move_reg <= move_reg - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_pc   = pc_reg;
  assign win_flag = win_reg;
  assign move_cnt = move_reg;
  assign hist_cnt = stack_cnt;
  assign illegal  = ill_reg;

endmodule

// File: tb/tb_puzzle_core.sv
// Directed scoreboard bench for puzzle_core with a behavioural board/history model.
module tb_puzzle_core;

  localparam logic [1:0] ST_CHOSE = 2'b00, ST_GAME = 2'b01, ST_INIT = 2'b10, ST_WIN = 2'b11;
  localparam logic [11:0] ORIGIN = 12'b001_011_000_010;
  localparam logic [11:0] TARGET = 12'b011_010_001_000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  game_status = ST_CHOSE;
  logic [3:0]  act = '0;
  logic        undo = 1'b0;
  logic [11:0] origin_bd = ORIGIN;
  logic [11:0] out_pc;
  logic        win_flag;
  logic [7:0]  move_cnt;
  logic [3:0]  hist_cnt;
  logic        illegal;

  puzzle_core #(.CELLS(4), .CW(3), .DEPTH(8), .MOVE_W(8)) dut (
    .clk(clk), .reset(reset), .game_status(game_status), .act(act), .undo(undo),
    .origin_bd(origin_bd), .out_pc(out_pc), .win_flag(win_flag), .move_cnt(move_cnt),
    .hist_cnt(hist_cnt), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] pc;
    logic [7:0]  mv;
    logic [3:0]  hc;
    logic        win;
    logic        ill;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;

  logic [11:0] m_board;
  int          m_move;
  int          m_hist[$];
  logic        m_win, m_ill, m_armed, m_uprev;
  logic [3:0]  m_prev;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [11:0] mswap(input logic [11:0] b, input int i);
    logic [11:0] r;
    logic [2:0]  t;
    int j;
    j = (i + 1) % 4;
    r = b;
    t = r[i*3 +: 3];
    r[i*3 +: 3] = r[j*3 +: 3];
    r[j*3 +: 3] = t;
    return r;
  endfunction

  task automatic model_reset();
    m_board = '0; m_move = 0; m_hist.delete(); m_win = 0; m_ill = 0;
    m_armed = 0; m_prev = '0; m_uprev = 0;
  endtask

  task automatic model_edge(input logic [1:0] st, input logic [3:0] a, input logic u);
    logic [3:0] p;
    logic       up;
    int         n, idx;
    p  = a & ~m_prev;
    up = u & ~m_uprev;
    n  = $countones(p) + int'(up);
    m_ill = 0;
    case (st)
      ST_CHOSE, ST_INIT: begin
        m_board = origin_bd; m_move = 0; m_hist.delete(); m_win = 0;
      end
      ST_GAME: begin
        m_win = (m_board == TARGET);
        if (m_armed) begin
          if (n > 1) m_ill = 1;
          else if (n == 1 && !up) begin
            idx = 0;
            for (int i = 0; i < 4; i++) if (p[i]) idx = i;
            m_board = mswap(m_board, idx);
            if (m_move < 255) m_move++;
            m_hist.push_back(idx);
            if (m_hist.size() > 8) void'(m_hist.pop_front());
          end else if (n == 1) begin
            if (m_hist.size() == 0) m_ill = 1;
            else begin
              idx = m_hist.pop_back();
              m_board = mswap(m_board, idx);
              if (m_move > 0) m_move--;
            end
          end
        end
      end
      default: ;
    endcase
    m_prev = a; m_uprev = u; m_armed = 1;
  endtask

  task automatic step(input logic [1:0] st, input logic [3:0] a, input logic u);
    exp_t e;
    game_status = st; act = a; undo = u;
    model_edge(st, a, u);
    e.pc = m_board; e.mv = 8'(m_move); e.hc = 4'(m_hist.size()); e.win = m_win; e.ill = m_ill;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk("out_pc", 32'(out_pc), 32'(e.pc));
      chk("move_cnt", 32'(move_cnt), 32'(e.mv));
      chk("hist_cnt", 32'(hist_cnt), 32'(e.hc));
      chk("win_flag", 32'(win_flag), 32'(e.win));
      chk("illegal", 32'(illegal), 32'(e.ill));
      $display("step st=%0d act=%b undo=%b -> pc=%b mv=%0d hc=%0d win=%b ill=%b",
               st, a, u, out_pc, move_cnt, hist_cnt, win_flag, illegal);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_pc"}, 32'(out_pc), 32'd0);
    chk({tag, "_mv"}, 32'(move_cnt), 32'd0);
    chk({tag, "_hc"}, 32'(hist_cnt), 32'd0);
    chk({tag, "_win"}, 32'(win_flag), 32'd0);
    chk({tag, "_ill"}, 32'(illegal), 32'd0);
  endtask

  initial begin
    model_reset();
    #1 reset = 1'b0;
    #1 check_zero("por");
    #10 reset = 1'b1;

    // Board load, then single press and held press
    step(ST_CHOSE, 4'b0000, 0);
    step(ST_CHOSE, 4'b0000, 0);
    chk("load_origin", 32'(out_pc), 32'(ORIGIN));
    step(ST_GAME, 4'b0000, 0);
    step(ST_GAME, 4'b0001, 0);
    chk("press0_pc", 32'(out_pc), 32'(12'b001_011_010_000));
    chk("press0_mv", 32'(move_cnt), 32'd1);
    for (int i = 0; i < 5; i++) step(ST_GAME, 4'b0001, 0);
    chk("held_pc", 32'(out_pc), 32'(12'b001_011_010_000));
    step(ST_GAME, 4'b0000, 0);

    // Solve: act0, act2, act1
    step(ST_INIT, 4'b0000, 0);
    step(ST_GAME, 4'b0001, 0);
    step(ST_GAME, 4'b0000, 0);
    step(ST_GAME, 4'b0100, 0);
    step(ST_GAME, 4'b0000, 0);
    step(ST_GAME, 4'b0010, 0);
    chk("solve_pc", 32'(out_pc), 32'(TARGET));
    chk("solve_win_late", 32'(win_flag), 32'd0);
    step(ST_GAME, 4'b0000, 0);
    chk("solve_win", 32'(win_flag), 32'd1);
    chk("solve_mv", 32'(move_cnt), 32'd3);

    // Frozen in WINNED, reload through GAME_INITIAL
    step(ST_WIN, 4'b0000, 0);
    step(ST_WIN, 4'b0100, 0);
    step(ST_WIN, 4'b0000, 0);
    chk("frozen_pc", 32'(out_pc), 32'(TARGET));
    chk("frozen_win", 32'(win_flag), 32'd1);
    step(ST_INIT, 4'b0000, 0);
    chk("reinit_pc", 32'(out_pc), 32'(ORIGIN));
    chk("reinit_mv", 32'(move_cnt), 32'd0);

    // Undo, then undo on empty history
    step(ST_GAME, 4'b0000, 0);
    step(ST_GAME, 4'b0001, 0);
    step(ST_GAME, 4'b0000, 0);
    step(ST_GAME, 4'b0000, 1);
    chk("undo_pc", 32'(out_pc), 32'(ORIGIN));
    chk("undo_hc", 32'(hist_cnt), 32'd0);
    step(ST_GAME, 4'b0000, 0);
    step(ST_GAME, 4'b0000, 1);
    chk("undo_empty_ill", 32'(illegal), 32'd1);
    step(ST_GAME, 4'b0000, 0);
    chk("ill_pulse_end", 32'(illegal), 32'd0);

    // Simultaneous presses, then history overflow and full unwind
    step(ST_GAME, 4'b1010, 0);
    chk("multi_ill", 32'(illegal), 32'd1);
    step(ST_GAME, 4'b0000, 0);
    step(ST_GAME, 4'b0001, 1);
    step(ST_GAME, 4'b0000, 0);
    for (int i = 0; i < 10; i++) begin
      step(ST_GAME, 4'b0001, 0);
      step(ST_GAME, 4'b0000, 0);
    end
    chk("ovf_hc", 32'(hist_cnt), 32'd8);
    chk("ovf_mv", 32'(move_cnt), 32'd10);
    for (int i = 0; i < 9; i++) begin
      step(ST_GAME, 4'b0000, 1);
      step(ST_GAME, 4'b0000, 0);
    end
    chk("unwind_mv", 32'(move_cnt), 32'd2);

    // Move counter saturation
    step(ST_INIT, 4'b0000, 0);
    for (int i = 0; i < 256; i++) begin
      step(ST_GAME, 4'b0100, 0);
      step(ST_GAME, 4'b0000, 0);
    end
    chk("sat_mv", 32'(move_cnt), 32'd255);
    step(ST_GAME, 4'b0000, 1);

    // Reset mid-game with act[0] held through release
    #2 reset = 1'b0;
    act = 4'b0001;
    model_reset();
    #1 check_zero("midrst");
    #2 reset = 1'b1;
    step(ST_GAME, 4'b0001, 0);
    step(ST_GAME, 4'b0001, 0);
    chk("held_rst_mv", 32'(move_cnt), 32'd0);
    step(ST_GAME, 4'b0000, 0);
    step(ST_GAME, 4'b0000, 1);
    chk("rst_hist_ill", 32'(illegal), 32'd1);
    step(ST_CHOSE, 4'b0000, 0);
    chk("rst_reload", 32'(out_pc), 32'(ORIGIN));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/puzzle_core.md
PUZZLE_CORE -- requirements
Module: puzzle_core

Interface
REQ-001 Parameter CELLS, default 4: number of board cells; legal range 2..16.
REQ-002 Parameter CW, default 3: bits per cell; CW SHALL be at least clog2(CELLS).
REQ-003 Parameter DEPTH, default 8: undo history depth; legal range 2..64.
REQ-004 Parameter MOVE_W, default 8: move counter width.
REQ-005 clk  in  1  the single clock; all state updates on its rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 game_status  in  2  mode: CHOSE_BOARD=00, GAMING=01, GAME_INITIAL=10, WINNED=11.
REQ-008 act  in  CELLS  level buttons; act[i] requests a swap of cell i with cell (i+1) mod CELLS.
REQ-009 undo  in  1  level button; requests reversal of the last recorded move.
REQ-010 origin_bd  in  CELLS*CW  start board; cell i occupies bits [i*CW +: CW].
REQ-011 out_pc  out  CELLS*CW  current board, registered.
REQ-012 win_flag  out  1  board solved, registered.
REQ-013 move_cnt  out  MOVE_W  net moves applied, registered.
REQ-014 hist_cnt  out  clog2(DEPTH+1)  entries held in the undo history.
REQ-015 illegal  out  1  one-cycle pulse for a rejected request.

Function
REQ-016 act and undo SHALL be registered each cycle; a press is a bit that is high now and was low the previous cycle; held levels SHALL NOT repeat.
REQ-017 In CHOSE_BOARD and GAME_INITIAL, out_pc SHALL load origin_bd every cycle, and move_cnt, hist_cnt and win_flag SHALL clear; presses are ignored.
REQ-018 In GAMING, a single act press SHALL swap the two cells at the same edge on which the press is detected (latency one edge), increment move_cnt (saturate at all-ones), and push index i to the history.
REQ-019 History full on push: the oldest entry SHALL be discarded (circular); hist_cnt stays DEPTH.
REQ-020 In GAMING, an undo press with hist_cnt>0 SHALL pop the newest index, reapply that swap, and decrement move_cnt (floor 0).
REQ-021 Undo press with hist_cnt=0: no state change; illegal pulses.
REQ-022 Two or more presses on the same edge (act bits and/or undo): no state change; illegal pulses.
REQ-023 win_flag SHALL assert one edge after out_pc equals target (cell i == i) while in GAMING, and deassert one edge after it no longer does.
REQ-024 In WINNED, out_pc, move_cnt, hist_cnt and win_flag SHALL hold; presses are ignored; illegal stays 0.
REQ-025 A change of game_status SHALL take effect on the next edge, with no pipeline drain.

Reset
REQ-026 Reset low SHALL clear out_pc, win_flag, move_cnt, hist_cnt, illegal, the history pointers and the press registers immediately.
REQ-027 An act bit still held at reset release SHALL NOT count as a press.
REQ-028 Reset mid-game SHALL discard all history; the board reloads only through CHOSE_BOARD or GAME_INITIAL.

Structure
REQ-029 Game-status encodings and the target-board function SHALL live in shared package game_pkg.
REQ-030 The undo history SHALL be sub-module move_stack: circular LIFO of clog2(CELLS)-bit entries, DEPTH deep, with push, pop, count, and drop-oldest on full.

Verification (defaults; origin_bd=12'b001_011_000_010)
REQ-031 Reset low mid-run -> all outputs 0 immediately; act[0] held through release -> no move.
REQ-032 CHOSE_BOARD then GAMING; press act[0] -> out_pc=12'b001_011_010_000, move_cnt=1; hold act[0] 5 cycles -> no further change.
REQ-033 Press act[0], act[2], act[1] -> out_pc=12'b011_010_001_000, win_flag=1 next edge, move_cnt=3.
REQ-034 Press act[0] then undo -> out_pc back to origin, move_cnt=0, hist_cnt=0; undo again -> illegal pulse, no change.
REQ-035 Press act[1] and act[3] on the same edge -> illegal=1 for one cycle, board unchanged; then 10 presses of act[0] -> hist_cnt=8, move_cnt=10.
REQ-036 Switch to WINNED after a win, then press act[2] -> outputs frozen; switch to GAME_INITIAL -> out_pc=origin, move_cnt=0.
